mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit.sv | 151 +++++++++++++++
 tb/tb_mem_access_unit.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit for an RV64 core: sized loads with sign/zero extension,
// doubleword stores direct, sub-doubleword stores as read-modify-write. Optional MISALIGN_TRAP_EN.
module mem_access_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        busy,
    output logic [63:0] load_data,
    output logic        load_valid,
    output logic        store_done,
    output logic        err,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    output logic        mem_write,
    output logic        mem_read,
    input  logic [63:0] mem_rdata
);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_RMW_WR = 1'b1;

    logic [0:0]  state_r;
    logic [63:0] addr_r;
    logic [63:0] merge_r;
    logic [63:0] load_data_r;
    logic        load_valid_r;
    logic        store_done_r;
    logic        err_r;

    logic        accept_s;
    logic        misalign_s;
    logic        reject_s;
    logic        load_go_s;
    logic        sd_go_s;
    logic        rmw_go_s;

    function automatic logic [63:0] extend_load(input logic [2:0] f3, input logic [63:0] d);
        case (f3)
            3'b000:  return {{56{d[7]}}, d[7:0]};
            3'b001:  return {{48{d[15]}}, d[15:0]};
            3'b010:  return {{32{d[31]}}, d[31:0]};
            3'b011:  return d;
            3'b100:  return {56'd0, d[7:0]};
            3'b101:  return {48'd0, d[15:0]};
            3'b110:  return {32'd0, d[31:0]};
            default: return 64'd0;
        endcase
    endfunction

    // Low 1/2/4 bytes come from the store data, the rest from the current memory contents.
    function automatic logic [63:0] merge_store(input logic [1:0] sz, input logic [63:0] wd,
                                                input logic [63:0] rd);
        case (sz)
            2'b00:   return {rd[63:8], wd[7:0]};
            2'b01:   return {rd[63:16], wd[15:0]};
            2'b10:   return {rd[63:32], wd[31:0]};
            default: return wd;
        endcase
    endfunction

`ifdef MISALIGN_TRAP_EN
    // Natural-alignment check per access size.
    always_comb begin
        case (req_funct3)
            3'b001, 3'b101: misalign_s = (req_addr[0] != 1'b0);
            3'b010, 3'b110: misalign_s = (req_addr[1:0] != 2'b00);
            3'b011:         misalign_s = (req_addr[2:0] != 3'b000);
            default:        misalign_s = 1'b0;
        endcase
    end
`else
    assign misalign_s = 1'b0;
`endif

    // Request classification; a request coinciding with reset is discarded.
    always_comb begin
        busy      = (state_r != ST_IDLE);
        accept_s  = req_valid && (state_r == ST_IDLE) && !reset;
        reject_s  = accept_s && ((req_funct3 == 3'b111) || (req_write && req_funct3[2]) || misalign_s);
        load_go_s = accept_s && !reject_s && !req_write;
        sd_go_s   = accept_s && !reject_s && req_write && (req_funct3[1:0] == 2'b11);
        rmw_go_s  = accept_s && !reject_s && req_write && (req_funct3[1:0] != 2'b11);
    end

    // Memory port drive; the pending merge write is dropped if reset arrives in RMW_WR.
    always_comb begin
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = 64'd0;
        mem_wdata = 64'd0;
        if (state_r == ST_RMW_WR) begin
            mem_write = !reset;
            mem_addr  = addr_r;
            mem_wdata = merge_r;
        end else if (load_go_s || rmw_go_s) begin
            mem_read  = 1'b1;
            mem_addr  = req_addr;
        end else if (sd_go_s) begin
            mem_write = 1'b1;
            mem_addr  = req_addr;
            mem_wdata = req_wdata;
        end else begin
            mem_read  = 1'b0;
        end
    end

    // State, result and strobe registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            addr_r       <= 64'd0;
            merge_r      <= 64'd0;
            load_data_r  <= 64'd0;
            load_valid_r <= 1'b0;
            store_done_r <= 1'b0;
            err_r        <= 1'b0;
        end else begin
            load_valid_r <= load_go_s;
            store_done_r <= sd_go_s || (state_r == ST_RMW_WR);
            err_r        <= reject_s;
            if (load_go_s) begin
                load_data_r <= extend_load(req_funct3, mem_rdata);
            end else begin
                load_data_r <= load_data_r;
            end
            case (state_r)
                ST_IDLE: begin
                    if (rmw_go_s) begin
                        state_r <= ST_RMW_WR;
                        addr_r  <= req_addr;
                        merge_r <= merge_store(req_funct3[1:0], req_wdata, mem_rdata);
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_RMW_WR: state_r <= ST_IDLE;
                default:   state_r <= ST_IDLE;
            endcase
        end
    end

    assign load_data  = load_data_r;
    assign load_valid = load_valid_r;
    assign store_done = store_done_r;
    assign err        = err_r;

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized bench for mem_access_unit against a byte-array reference memory model.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic        busy;
    logic [63:0] load_data;
    logic        load_valid;
    logic        store_done;
    logic        err;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic        mem_write;
    logic        mem_read;
    logic [63:0] mem_rdata;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] env_mem [0:255];
    logic [7:0] ref_mem [0:255];

    mem_access_unit dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_write(req_write),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .busy(busy), .load_data(load_data), .load_valid(load_valid),
        .store_done(store_done), .err(err), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_write(mem_write), .mem_read(mem_read), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Environment memory: combinational 8-byte read, posedge 8-byte write.
    always_comb begin
        mem_rdata = 64'd0;
        for (int i = 0; i < 8; i++) mem_rdata[8*i +: 8] = env_mem[8'(mem_addr[7:0] + 8'(i))];
    end

    always @(posedge clk) begin
        if (mem_write)
            for (int i = 0; i < 8; i++) env_mem[8'(mem_addr[7:0] + 8'(i))] <= mem_wdata[8*i +: 8];
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] word_at(input bit use_ref, input int a);
        logic [63:0] v = 64'd0;
        for (int i = 0; i < 8; i++)
            v[8*i +: 8] = use_ref ? ref_mem[(a + i) & 255] : env_mem[(a + i) & 255];
        return v;
    endfunction

    function automatic logic [63:0] ref_load(input logic [2:0] f3, input int a);
        int size = 1 << f3[1:0];
        logic [63:0] v = 64'd0;
        for (int i = 0; i < size; i++) v = v | (64'(ref_mem[(a + i) & 255]) << (8 * i));
        if (!f3[2] && size < 8 && v[8*size-1]) v = v | (~64'd0 << (8 * size));
        return v;
    endfunction

    function automatic bit ref_legal(input logic w, input logic [2:0] f3, input int a);
        if (f3 == 3'b111) return 1'b0;
        if (w && f3[2]) return 1'b0;
`ifdef MISALIGN_TRAP_EN
        if ((a % (1 << f3[1:0])) != 0) return 1'b0;
`endif
        return 1'b1;
    endfunction

    task automatic preset(input int a, input logic [63:0] v);
        for (int i = 0; i < 8; i++) begin
            env_mem[(a + i) & 255] = v[8*i +: 8];
            ref_mem[(a + i) & 255] = v[8*i +: 8];
        end
    endtask

    task automatic ref_store(input logic [2:0] f3, input int a, input logic [63:0] wd);
        for (int i = 0; i < (1 << f3[1:0]); i++) ref_mem[(a + i) & 255] = wd[8*i +: 8];
    endtask

    // One complete request from an idle unit, checked cycle by cycle.
    task automatic do_op(input logic w, input logic [2:0] f3, input int a, input logic [63:0] wd);
        bit legal = ref_legal(w, f3, a);
        bit is_load = legal && !w;
        bit is_sd = legal && w && (f3 == 3'b011);
        bit is_rmw = legal && w && (f3 != 3'b011);
        logic [63:0] exp_ld = ref_load(f3, a);
        @(negedge clk);
        req_valid = 1'b1; req_write = w; req_funct3 = f3; req_addr = 64'(a); req_wdata = wd;
        #1;
        check_eq("busy_acc", 64'(busy), 64'd0);
        check_eq("rd_acc", 64'(mem_read), 64'(is_load || is_rmw));
        check_eq("wr_acc", 64'(mem_write), 64'(is_sd));
        if (legal) check_eq("addr_acc", mem_addr, 64'(a));
        @(posedge clk); #1;
        req_valid = 1'b0;
        check_eq("load_valid", 64'(load_valid), 64'(is_load));
        check_eq("err", 64'(err), 64'(!legal));
        check_eq("store_done", 64'(store_done), 64'(is_sd));
        if (is_load) check_eq("load_data", load_data, exp_ld);
        check_eq("busy", 64'(busy), 64'(is_rmw));
        if (is_rmw) begin
            check_eq("rmw_wr", 64'(mem_write), 64'd1);
            check_eq("rmw_rd", 64'(mem_read), 64'd0);
            check_eq("rmw_addr", mem_addr, 64'(a));
            @(posedge clk); #1;
            check_eq("rmw_done", 64'(store_done), 64'd1);
            check_eq("rmw_busy", 64'(busy), 64'd0);
            check_eq("rmw_idle_wr", 64'(mem_write), 64'd0);
        end
        if (is_sd || is_rmw) ref_store(f3, a, wd);
        check_eq("mem", word_at(1'b0, a), word_at(1'b1, a));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [63:0] merged;
        for (int i = 0; i < 256; i++) begin
            env_mem[i] = 8'($urandom);
            ref_mem[i] = env_mem[i];
        end
        reset = 1'b1; req_valid = 1'b0; req_write = 1'b0;
        req_funct3 = 3'b000; req_addr = 64'd0; req_wdata = 64'd0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_ld", load_data, 64'd0);
        check_eq("rst_strobes", {61'd0, load_valid, store_done, err}, 64'd0);
        @(negedge clk); reset = 1'b0;

        // Directed vectors.
        preset(8, 64'h1E);
        do_op(1'b0, 3'b011, 8, 64'd0);
        check_eq("ld8_const", load_data, 64'h1E);
        preset(16, 64'h00000000000000F3);
        do_op(1'b0, 3'b000, 16, 64'd0);
        check_eq("lb16_const", load_data, 64'hFFFF_FFFF_FFFF_FFF3);
        do_op(1'b0, 3'b100, 16, 64'd0);
        check_eq("lbu16_const", load_data, 64'h0000_0000_0000_00F3);
        preset(24, 64'h09);
        do_op(1'b1, 3'b000, 24, 64'hAB);
        check_eq("sb24_const", word_at(1'b0, 24), 64'hAB);
        do_op(1'b0, 3'b010, 10, 64'd0);

        // sw with a second request held while busy.
        preset(32, 64'hDEADBEEF_CAFEF00D);
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b010; req_addr = 64'd32;
        req_wdata = 64'h1122334455667788;
        @(negedge clk);
        req_write = 1'b0; req_funct3 = 3'b011; req_addr = 64'd32; req_wdata = 64'd0;
        #1;
        check_eq("held_busy", 64'(busy), 64'd1);
        check_eq("held_no_rd", 64'(mem_read), 64'd0);
        check_eq("held_wdata", mem_wdata, 64'hDEADBEEF_55667788);
        @(posedge clk); #1;
        ref_store(3'b010, 32, 64'h1122334455667788);
        check_eq("held_done", 64'(store_done), 64'd1);
        check_eq("held_no_lv", 64'(load_valid), 64'd0);
        check_eq("sw32_mem", word_at(1'b0, 32), 64'hDEADBEEF_55667788);
        @(negedge clk); #1;
        check_eq("held_acc_rd", 64'(mem_read), 64'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        check_eq("held_lv", 64'(load_valid), 64'd1);
        check_eq("held_ld", load_data, ref_load(3'b011, 32));

        // Reset during the RMW_WR cycle of sh 40.
        preset(40, 64'h0102030405060708);
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b001; req_addr = 64'd40;
        req_wdata = 64'hFFFF;
        @(posedge clk); #1;
        req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'b000; req_addr = 64'd0; req_wdata = 64'd0;
        @(negedge clk); reset = 1'b1; #1;
        check_eq("rst_rmw_wr", 64'(mem_write), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        check_eq("rst_rmw_busy", 64'(busy), 64'd0);
        check_eq("rst_rmw_outs", {58'd0, load_valid, store_done, err, mem_write, mem_read, busy}, 64'd0);
        check_eq("rst_rmw_ports", load_data | mem_addr | mem_wdata, 64'd0);
        @(posedge clk); #1;
        check_eq("rst_rmw_nodone", 64'(store_done), 64'd0);
        check_eq("rst_rmw_mem", word_at(1'b0, 40), 64'h0102030405060708);

        // Request coinciding with reset is discarded.
        preset(48, 64'h5555);
        @(negedge clk);
        reset = 1'b1; req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b011;
        req_addr = 64'd48; req_wdata = 64'hAAAA;
        #1;
        check_eq("rst_req_wr", 64'(mem_write), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0; req_valid = 1'b0;
        check_eq("rst_req_done", 64'(store_done), 64'd0);
        check_eq("rst_req_mem", word_at(1'b0, 48), 64'h5555);

        // Random traffic.
        for (int k = 0; k < 300; k++) begin
            merged = {$urandom, $urandom};
            do_op(1'($urandom), 3'($urandom), int'($urandom_range(0, 247)), merged);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
